// File: rtl/pc_source_unit_pkg.sv
// Shared PC-source encodings, opcode values and NOP word used by the fetch-side
// control unit and the PC module.
package pc_source_unit_pkg;

    typedef enum logic [1:0] {
        PC_Src_Dft = 2'b00,
        PC_Src_Ra  = 2'b01,
        PC_Src_Jmp = 2'b10,
        PC_Src_BTA = 2'b11
    } pc_src_e;

    localparam logic [5:0]  OP_BEQ  = 6'h1C;
    localparam logic [5:0]  OP_BNE  = 6'h1D;
    localparam logic [5:0]  OP_JMP  = 6'h1E;
    localparam logic [5:0]  OP_CALL = 6'h1F;
    localparam logic [5:0]  OP_RET  = 6'h20;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/pc_source_unit_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry; a pop from an empty stack leaves state untouched and flags underflow.
module return_address_stack
    import pc_source_unit_pkg::*;
#(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_dat,
    output logic [31:0] pop_dat,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        underflow
);

    localparam int SP_W  = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      mem_q [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_dec;
    logic [CNT_W-1:0] count_q;

    // sp points at the next free slot; when full that slot is the oldest entry
    assign sp_dec    = sp_q - SP_W'(1);
    assign full      = (count_q == CNT_W'(RAS_DEPTH));
    assign empty     = (count_q == '0);
    assign pop_dat   = empty ? 32'h0 : mem_q[sp_dec];
    assign overflow  = push && full;
    assign underflow = pop && empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q    <= '0;
            count_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SP_W'(1);
            if (!full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            sp_q    <= sp_dec;
            count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[sp_q] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_source_unit.sv
// Fetch-side control: instruction register, immediate extraction, CALL/RET
// return-address stack and PC-source select for the PC module.
module pc_source_unit
    import pc_source_unit_pkg::*;
#(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] I_TypeImmediate,
    output logic [31:0] J_TypeImmediate,
    output logic [31:0] ReturnAddress,
    output logic [1:0]  sig_pc_src,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] ra_q, ra_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    logic        capture;
    logic        ras_push, ras_pop;
    logic [31:0] ras_pop_dat;
    logic        ras_full, ras_empty;
    logic        ras_ovf_pls, ras_udf_pls;
    logic        unused_ras_full;
    logic [5:0]  in_op, ir_op;

    assign in_op    = opcode_of(instruction);
    assign ir_op    = opcode_of(ir_q);
    assign capture  = !stall && instr_valid;
    assign ras_push = capture && (in_op == OP_CALL);
    assign ras_pop  = capture && (in_op == OP_RET);

    assign unused_ras_full = ras_full;

    return_address_stack #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_dat  (pc + 32'd1),
        .pop_dat   (ras_pop_dat),
        .full      (ras_full),
        .empty     (ras_empty),
        .overflow  (ras_ovf_pls),
        .underflow (ras_udf_pls)
    );

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ra_d       = ra_q;
        ovf_d      = ovf_q | ras_ovf_pls;
        udf_d      = udf_q | ras_udf_pls;
        if (!stall) begin
            ir_d       = instr_valid ? instruction : NOP;
            ir_valid_d = instr_valid;
        end
        if (ras_pop) begin
            ra_d = ras_empty ? 32'h0 : ras_pop_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            ra_q       <= 32'h0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ra_q       <= ra_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // branch_taken is consumed live: it belongs to the branch currently in IR
    always_comb begin
        sig_pc_src = PC_Src_Dft;
        if (ir_valid_q) begin
            case (ir_op)
                OP_JMP, OP_CALL: sig_pc_src = PC_Src_Jmp;
                OP_RET:          sig_pc_src = PC_Src_Ra;
                OP_BEQ, OP_BNE:  sig_pc_src = branch_taken ? PC_Src_BTA : PC_Src_Dft;
                default:         sig_pc_src = PC_Src_Dft;
            endcase
        end
    end

    assign ir              = ir_q;
    assign ir_valid        = ir_valid_q;
    assign I_TypeImmediate = {{16{ir_q[15]}}, ir_q[15:0]};
    assign J_TypeImmediate = {{6{ir_q[25]}}, ir_q[25:0]};
    assign ReturnAddress   = ra_q;
    assign ras_overflow    = ovf_q;
    assign ras_underflow   = udf_q;

endmodule

// File: tb/tb_pc_source_unit.sv
// Directed bench for pc_source_unit with hand-computed expectations.
module tb_pc_source_unit;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] I_TypeImmediate;
    logic [31:0] J_TypeImmediate;
    logic [31:0] ReturnAddress;
    logic [1:0]  sig_pc_src;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] W_JMP   = 32'h7BFF_FFF6; // {6'h1E, 26'h3FFFFF6}
    localparam logic [31:0] W_CALL  = 32'h7C00_0000; // {6'h1F, 26'h0}
    localparam logic [31:0] W_RET   = 32'h8000_0000; // {6'h20, 26'h0}
    localparam logic [31:0] W_BEQ   = 32'h7000_0008; // {6'h1C, 10'h0, 16'd8}
    localparam logic [31:0] W_JMP30 = 32'h7800_0010; // {6'h1E, 26'h10}

    pc_source_unit #(.RAS_DEPTH(8)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .I_TypeImmediate (I_TypeImmediate),
        .J_TypeImmediate (J_TypeImmediate),
        .ReturnAddress   (ReturnAddress),
        .sig_pc_src      (sig_pc_src),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] word, input logic [31:0] addr);
        instruction = word;
        pc          = addr;
        instr_valid = 1'b1;
    endtask

    function automatic logic [31:0] ras_count();
        return 32'(u_dut.u_ras.count_q);
    endfunction

    initial begin
        reset        = 1'b1;
        pc           = 32'h0;
        instruction  = 32'h0;
        instr_valid  = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ir",       ir, 32'h0);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_ra",       ReturnAddress, 32'h0);
        check("rst_src",      32'(sig_pc_src), 32'h0);
        check("rst_ovf",      32'(ras_overflow), 32'h0);
        check("rst_udf",      32'(ras_underflow), 32'h0);

        // JMP with negative 26-bit offset
        present(W_JMP, 32'd5);
        tick();
        check("jmp_jimm",     J_TypeImmediate, 32'hFFFF_FFF6);
        check("jmp_iimm",     I_TypeImmediate, 32'hFFFF_FFF6);
        check("jmp_src",      32'(sig_pc_src), 32'h2);
        check("jmp_ir_valid", 32'(ir_valid), 32'h1);

        // CALL then RET back-to-back
        present(W_CALL, 32'd20);
        tick();
        check("call_src",   32'(sig_pc_src), 32'h2);
        check("call_count", ras_count(), 32'd1);
        present(W_RET, 32'd21);
        tick();
        check("ret_ra",    ReturnAddress, 32'd21);
        check("ret_src",   32'(sig_pc_src), 32'h1);
        check("ret_count", ras_count(), 32'd0);

        // BEQ: not taken then taken in the same IR cycle
        present(W_BEQ, 32'd22);
        branch_taken = 1'b0;
        tick();
        check("beq_nt_src", 32'(sig_pc_src), 32'h0);
        branch_taken = 1'b1;
        #1;
        check("beq_t_src",  32'(sig_pc_src), 32'h3);
        check("beq_iimm",   I_TypeImmediate, 32'd8);

        // bubble: NOP in IR, select forced to default
        instr_valid = 1'b0;
        tick();
        check("bub_ir",       ir, 32'h0);
        check("bub_ir_valid", 32'(ir_valid), 32'h0);
        check("bub_src",      32'(sig_pc_src), 32'h0);
        check("bub_ra",       ReturnAddress, 32'd21);
        branch_taken = 1'b0;

        // 9 CALLs overflow the 8-deep stack
        for (int i = 0; i < 9; i++) begin
            present(W_CALL, 32'(i));
            tick();
            if (i == 7) check("ovf_before", 32'(ras_overflow), 32'h0);
        end
        check("ovf_after", 32'(ras_overflow), 32'h1);
        check("ovf_count", ras_count(), 32'd8);

        for (int i = 0; i < 9; i++) begin
            present(W_RET, 32'd100 + 32'(i));
            tick();
            if (i < 8) check($sformatf("ret_seq%0d", i), ReturnAddress, 32'(9 - i));
            if (i == 7) check("udf_before", 32'(ras_underflow), 32'h0);
        end
        check("udf_ra",    ReturnAddress, 32'h0);
        check("udf_after", 32'(ras_underflow), 32'h1);
        check("udf_ovf_sticky", 32'(ras_overflow), 32'h1);

        // reset clears sticky flags
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_ovf", 32'(ras_overflow), 32'h0);
        check("rst2_udf", 32'(ras_underflow), 32'h0);

        // stall holds everything for 3 cycles
        present(W_JMP30, 32'd30);
        tick();
        present(W_CALL, 32'd40);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_ir%0d", i),    ir, W_JMP30);
            check($sformatf("stall_src%0d", i),   32'(sig_pc_src), 32'h2);
            check($sformatf("stall_jimm%0d", i),  J_TypeImmediate, 32'h10);
            check($sformatf("stall_count%0d", i), ras_count(), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("post_stall_ir",    ir, W_CALL);
        check("post_stall_count", ras_count(), 32'd1);
        present(W_RET, 32'd41);
        tick();
        check("post_stall_ra",    ReturnAddress, 32'd41);

        // CALL accepted, then reset on the next edge
        present(W_CALL, 32'd50);
        tick();
        check("prerst_count", ras_count(), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ir",       ir, 32'h0);
        check("midrst_ir_valid", 32'(ir_valid), 32'h0);
        check("midrst_count",    ras_count(), 32'd0);
        check("midrst_ovf",      32'(ras_overflow), 32'h0);
        check("midrst_udf",      32'(ras_underflow), 32'h0);
        present(W_RET, 32'd52);
        tick();
        check("midrst_ret_ra",  ReturnAddress, 32'h0);
        check("midrst_ret_udf", 32'(ras_underflow), 32'h1);
        check("midrst_ret_src", 32'(sig_pc_src), 32'h1);

        instr_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
